// File: rtl/cpu_op_sequencer.sv
// Command sequencer for the 32x32 register-file / add-sub cpu datapath.
// Translates one WRITE/READ/ADD/SUB command at a time into held control encodings and returns the result.
module cpu_op_sequencer #(
   parameter int HOLD_CYCLES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [4:0]       cmd_a,
   input  logic [4:0]       cmd_b,
   input  logic [31:0]      cmd_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic             rsp_over,
   output logic             ovf_sticky,
   input  logic             clr_ovf,
   output logic [CNT_W-1:0] ops_done,
   output logic [4:0]       dp_addressA,
   output logic [4:0]       dp_addressB,
   output logic [31:0]      dp_dataIn,
   output logic             dp_asel,
   output logic             dp_bsel,
   output logic [1:0]       dp_opsel,
   output logic [1:0]       dp_outsel,
   output logic             dp_oen,
   input  logic [31:0]      dp_outPut,
   input  logic             dp_over
);

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t      state, state_nx;
   logic [3:0]  hold_cnt;
   logic [1:0]  op_q;
   logic        accept, capture;

   logic [4:0]  enc_a, enc_b;
   logic [31:0] enc_d;
   logic        enc_asel, enc_bsel, enc_oen;
   logic [1:0]  enc_opsel, enc_outsel;

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      capture  = 1'b0;
      case (state)
         IDLE:  if (cmd_valid) begin
                   accept   = 1'b1;
                   state_nx = ISSUE;
                end
         ISSUE: if (hold_cnt == 4'd0) begin
                   capture  = 1'b1;
                   state_nx = (op_q == OP_WRITE) ? IDLE : RESP;
                end
         RESP:  if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Command-to-control translation; defaults are the READ-style pass-through.
   always_comb begin
      enc_a      = 5'd0;
      enc_b      = 5'd0;
      enc_d      = 32'd0;
      enc_asel   = 1'b1;
      enc_bsel   = 1'b0;
      enc_opsel  = 2'b01;
      enc_outsel = 2'b00;
      enc_oen    = 1'b1;
      case (cmd_op)
         2'b00: begin
            enc_b    = cmd_b;
            enc_d    = cmd_data;
            enc_asel = 1'b0;
         end
         2'b01: begin
            enc_a = cmd_a;
            enc_b = cmd_a;
         end
         default: begin
            enc_a      = cmd_a;
            enc_b      = cmd_b;
            enc_bsel   = 1'b1;
            enc_outsel = 2'b01;
            enc_opsel  = (cmd_op == 2'b10) ? 2'b00 : 2'b01;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Datapath controls fall back to the non-destructive r0 read whenever no command is held.
   always_ff @(posedge clk) begin
      if (!rst_n || capture) begin
         dp_addressA <= 5'd0;
         dp_addressB <= 5'd0;
         dp_dataIn   <= 32'd0;
         dp_asel     <= 1'b1;
         dp_bsel     <= 1'b0;
         dp_opsel    <= 2'b01;
         dp_outsel   <= 2'b00;
         dp_oen      <= 1'b0;
      end else if (accept) begin
         dp_addressA <= enc_a;
         dp_addressB <= enc_b;
         dp_dataIn   <= enc_d;
         dp_asel     <= enc_asel;
         dp_bsel     <= enc_bsel;
         dp_opsel    <= enc_opsel;
         dp_outsel   <= enc_outsel;
         dp_oen      <= enc_oen;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_data   <= 32'd0;
         rsp_over   <= 1'b0;
         ovf_sticky <= 1'b0;
         ops_done   <= '0;
         hold_cnt   <= 4'd0;
         op_q       <= OP_WRITE;
      end else begin
         cmd_ready <= (state_nx == IDLE);
         if (accept) begin
            op_q     <= cmd_op;
            hold_cnt <= 4'(HOLD_CYCLES - 1);
         end else if (state == ISSUE && hold_cnt != 4'd0) begin
            hold_cnt <= hold_cnt - 4'd1;
         end
         if (capture) begin
            rsp_data <= dp_outPut;
            rsp_over <= (op_q == OP_READ) ? 1'b0 : dp_over;
            ops_done <= ops_done + CNT_W'(1);
         end
         if (capture && op_q != OP_WRITE)
            rsp_valid <= 1'b1;
         else if (state == RESP && rsp_ready)
            rsp_valid <= 1'b0;
         // A fresh overflow beats a simultaneous clear.
         if (capture && op_q[1] && dp_over)
            ovf_sticky <= 1'b1;
         else if (clr_ovf)
            ovf_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cpu_op_sequencer.sv
// Bench for cpu_op_sequencer: behavioural cpu datapath stand-in plus a command-level reference model.
module tb_cpu_op_sequencer;
   localparam int HOLD  = 2;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_over, ovf_sticky, clr_ovf;
   logic [1:0] cmd_op, dp_opsel, dp_outsel;
   logic [4:0] cmd_a, cmd_b, dp_addressA, dp_addressB;
   logic [31:0] cmd_data, rsp_data, dp_dataIn, dp_outPut;
   logic [CNT_W-1:0] ops_done;
   logic dp_asel, dp_bsel, dp_oen, dp_over;

   cpu_op_sequencer #(.HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_over(rsp_over),
      .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf), .ops_done(ops_done),
      .dp_addressA(dp_addressA), .dp_addressB(dp_addressB), .dp_dataIn(dp_dataIn),
      .dp_asel(dp_asel), .dp_bsel(dp_bsel), .dp_opsel(dp_opsel), .dp_outsel(dp_outsel),
      .dp_oen(dp_oen), .dp_outPut(dp_outPut), .dp_over(dp_over));

   // cpu stand-in: outsel 00 writes the A-path value to reg[addressB] and shows it; outsel 01 shows the ALU.
   logic [31:0] rf [32] = '{default: 32'h0};
   logic [31:0] opa, opb, wrv, alu;
   logic        alu_ov;
   always_comb begin
      opa    = rf[dp_addressA];
      opb    = dp_bsel ? rf[dp_addressB] : 32'h0;
      wrv    = dp_asel ? opa : dp_dataIn;
      alu    = (dp_opsel == 2'b00) ? opa + opb : opa - opb;
      alu_ov = (dp_opsel == 2'b00) ? (opa[31] == opb[31] && alu[31] != opa[31])
                                   : (opa[31] != opb[31] && alu[31] != opa[31]);
      dp_outPut = !dp_oen ? 32'h0 : ((dp_outsel == 2'b01) ? alu : wrv);
      dp_over   = dp_oen && dp_outsel == 2'b01 && alu_ov;
   end
   always @(posedge clk) if (dp_outsel == 2'b00) rf[dp_addressB] <= wrv;

   logic [48:0] enc_obs;
   assign enc_obs = {dp_addressA, dp_addressB, dp_dataIn, dp_asel, dp_bsel, dp_opsel, dp_outsel, dp_oen};
   localparam logic [48:0] IDLE_ENC = {5'd0, 5'd0, 32'd0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0};

   int n_chk = 0, n_fail = 0;
   logic [31:0]      exp_rf [32];
   logic [CNT_W-1:0] exp_ops;
   logic             exp_ovf;

   task automatic run_cmd(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                          input logic [31:0] d, input int wait_n, input bit clr_hold, input bit extra_valid);
      logic [48:0] enc;
      logic [31:0] res, x, y;
      logic        ov;
      int          cnt;
      x = exp_rf[a]; y = exp_rf[b]; ov = 1'b0; res = 32'h0;
      case (op)
         2'b00: begin enc = {5'd0, b, d, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1}; exp_rf[b] = d; end
         2'b01: begin enc = {a, a, 32'd0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1}; res = x; end
         2'b10: begin
            enc = {a, b, 32'd0, 1'b1, 1'b1, 2'b00, 2'b01, 1'b1};
            res = x + y; ov = (x[31] == y[31]) && (res[31] != x[31]);
         end
         default: begin
            enc = {a, b, 32'd0, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1};
            res = x - y; ov = (x[31] != y[31]) && (res[31] != x[31]);
         end
      endcase
      @(negedge clk);
      n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_ready_before: got %b want 1", cmd_ready); end
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_data = d;
      @(negedge clk);
      cmd_valid = 1'b0; clr_ovf = clr_hold;
      cnt = 0;
      while (dp_oen === 1'b1 && cnt < 40) begin
         n_chk++; if (enc_obs !== enc) begin n_fail++; $display("FAIL encoding op%0d cyc%0d: got %h want %h", op, cnt, enc_obs, enc); end
         n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL cmd_ready_issue: got %b want 0", cmd_ready); end
         cmd_op = 2'($urandom); cmd_a = 5'($urandom); cmd_b = 5'($urandom); cmd_data = $urandom;
         cnt++;
         @(negedge clk);
      end
      clr_ovf = 1'b0;
      n_chk++; if (cnt != HOLD) begin n_fail++; $display("FAIL hold_cycles op%0d: got %0d want %0d", op, cnt, HOLD); end
      n_chk++; if (enc_obs !== IDLE_ENC) begin n_fail++; $display("FAIL idle_after: got %h want %h", enc_obs, IDLE_ENC); end
      exp_ops = exp_ops + 1'b1;
      if (clr_hold) exp_ovf = 1'b0;
      if (op[1] && ov) exp_ovf = 1'b1;
      n_chk++; if (ops_done !== exp_ops) begin n_fail++; $display("FAIL ops_done: got %0d want %0d", ops_done, exp_ops); end
      n_chk++; if (ovf_sticky !== exp_ovf) begin n_fail++; $display("FAIL ovf_sticky: got %b want %b", ovf_sticky, exp_ovf); end
      if (op == 2'b00) begin
         n_chk++; if ({cmd_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL write_done ready/valid: got %b want 10", {cmd_ready, rsp_valid}); end
      end else begin
         for (int i = 0; i <= wait_n; i++) begin
            n_chk++; if ({rsp_valid, cmd_ready} !== 2'b10) begin n_fail++; $display("FAIL rsp_hold valid/ready: got %b want 10", {rsp_valid, cmd_ready}); end
            n_chk++; if ({rsp_data, rsp_over} !== {res, ov}) begin n_fail++; $display("FAIL rsp_result op%0d: got %h/%b want %h/%b", op, rsp_data, rsp_over, res, ov); end
            if (i < wait_n) begin
               if (extra_valid) begin cmd_valid = 1'b1; cmd_op = 2'b00; cmd_b = 5'($urandom); cmd_data = $urandom; end
               @(negedge clk);
               n_chk++; if (dp_oen !== 1'b0) begin n_fail++; $display("FAIL ignored_cmd: got oen %b want 0", dp_oen); end
            end
         end
         cmd_valid = 1'b0; rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         n_chk++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL rsp_release valid/ready: got %b want 01", {rsp_valid, cmd_ready}); end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++; if ({cmd_ready, rsp_valid, rsp_data, rsp_over, ovf_sticky} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL reset_outputs: got %b %b %h %b %b want 1 0 0 0 0", cmd_ready, rsp_valid, rsp_data, rsp_over, ovf_sticky); end
      n_chk++; if (ops_done !== '0) begin n_fail++; $display("FAIL reset_ops_done: got %0d want 0", ops_done); end
      n_chk++; if (enc_obs !== IDLE_ENC) begin n_fail++; $display("FAIL reset_encoding: got %h want %h", enc_obs, IDLE_ENC); end
      rst_n = 1'b1;
      exp_ops = '0; exp_ovf = 1'b0;
   endtask

   task automatic test_write;
      run_cmd(2'b00, 5'd0, 5'd0, 32'h0A0B1C1D, 0, 0, 0);
      run_cmd(2'b00, 5'd0, 5'd1, 32'h22223333, 0, 0, 0);
   endtask

   task automatic test_add;
      run_cmd(2'b10, 5'd0, 5'd1, 32'h0, 1, 0, 0);
      n_chk++; if (rsp_data !== 32'h2C2D4F50) begin n_fail++; $display("FAIL add_literal: got %h want 2c2d4f50", rsp_data); end
   endtask

   task automatic test_sub;
      run_cmd(2'b00, 5'd0, 5'd4, 32'hABCDEF01, 0, 0, 0);
      run_cmd(2'b00, 5'd0, 5'd5, 32'hFFFF0000, 0, 0, 0);
      run_cmd(2'b11, 5'd4, 5'd5, 32'h0, 0, 0, 0);
      n_chk++; if ({rsp_data, ovf_sticky} !== {32'hABCEEF01, 1'b0}) begin n_fail++; $display("FAIL sub_literal: got %h/%b want abceef01/0", rsp_data, ovf_sticky); end
   endtask

   task automatic test_overflow;
      run_cmd(2'b00, 5'd0, 5'd6, 32'h7FFFFFFF, 0, 0, 0);
      run_cmd(2'b00, 5'd0, 5'd7, 32'h00000001, 0, 0, 0);
      run_cmd(2'b10, 5'd6, 5'd7, 32'h0, 0, 0, 0);
      n_chk++; if ({rsp_data, ovf_sticky} !== {32'h80000000, 1'b1}) begin n_fail++; $display("FAIL ovf_literal: got %h/%b want 80000000/1", rsp_data, ovf_sticky); end
      clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0; exp_ovf = 1'b0;
      n_chk++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", ovf_sticky); end
      // clear held across the capture edge: the new overflow must survive
      run_cmd(2'b10, 5'd6, 5'd7, 32'h0, 0, 1, 0);
      clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0; exp_ovf = 1'b0;
   endtask

   task automatic test_back_pressure;
      run_cmd(2'b01, 5'd1, 5'd0, 32'h0, 5, 0, 1);
   endtask

   task automatic test_random;
      for (int k = 0; k < 24; k++)
         run_cmd(2'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom_range(0, 3), 0, bit'($urandom_range(0, 1)));
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 5'd6; cmd_b = 5'd7;
      @(negedge clk);
      cmd_valid = 1'b0;
      n_chk++; if (dp_oen !== 1'b1) begin n_fail++; $display("FAIL mid_issue_oen: got %b want 1", dp_oen); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_chk++; if (enc_obs !== IDLE_ENC) begin n_fail++; $display("FAIL mid_reset_enc: got %h want %h", enc_obs, IDLE_ENC); end
      n_chk++; if ({rsp_valid, cmd_ready, ops_done} !== {1'b0, 1'b1, {CNT_W{1'b0}}}) begin
         n_fail++; $display("FAIL mid_reset_state: got %b %b %0d want 0 1 0", rsp_valid, cmd_ready, ops_done); end
      repeat (3) @(negedge clk);
      n_chk++; if ({rsp_valid, dp_oen, ops_done} !== {1'b0, 1'b0, {CNT_W{1'b0}}}) begin
         n_fail++; $display("FAIL mid_reset_dropped: got %b %b %0d want 0 0 0", rsp_valid, dp_oen, ops_done); end
      exp_ops = '0; exp_ovf = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
      exp_ops = '0; exp_ovf = 1'b0;
      cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = 5'd0; cmd_b = 5'd0; cmd_data = 32'h0;
      rsp_ready = 1'b0; clr_ovf = 1'b0; rst_n = 1'b1;
      test_reset;
      test_write;
      test_add;
      test_sub;
      test_overflow;
      test_back_pressure;
      test_random;
      test_reset_mid;
      run_cmd(2'b11, 5'd1, 5'd0, 32'h0, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
